// File: rtl/autosym_pkg.sv
// Shared constants, FSM state type and the GF(2) row dot product for the
// autosymmetry projection stage.
package autosym_pkg;

  localparam int AUTOSYM_N_IN  = 24;
  localparam int AUTOSYM_N_OUT = 16;
  // Widest row the dot-product helper handles; callers zero-extend into it.
  localparam int AUTOSYM_MAX_W = 64;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } autosym_state_e;

  function automatic logic gf2_row_dot(
    input logic [AUTOSYM_MAX_W-1:0] row,
    input logic [AUTOSYM_MAX_W-1:0] x
  );
    return ^(row & x);
  endfunction

endpackage

// File: rtl/autosym_xor_reduce.sv
// Combinational GF(2) matrix-vector product z = A*x, one parity per matrix row.
module autosym_xor_reduce
  import autosym_pkg::*;
#(
  parameter int N_IN  = AUTOSYM_N_IN,
  parameter int N_OUT = AUTOSYM_N_OUT
) (
  input  logic [N_OUT-1:0][N_IN-1:0] matrix_i,
  input  logic [N_IN-1:0]            x_i,
  output logic [N_OUT-1:0]           z_o
);

  // Per-row parity of the masked input vector
  always_comb begin
    logic [AUTOSYM_MAX_W-1:0] row_ext;
    logic [AUTOSYM_MAX_W-1:0] x_ext;
    z_o              = '0;
    row_ext          = '0;
    x_ext            = '0;
    x_ext[N_IN-1:0]  = x_i;
    for (int i = 0; i < N_OUT; i++) begin
      row_ext           = '0;
      row_ext[N_IN-1:0] = matrix_i[i];
      z_o[i]            = gf2_row_dot(row_ext, x_ext);
    end
  end

endmodule

// File: rtl/autosym_proj_stage.sv
// Two-stage streaming GF(2) projection with a run-time loadable matrix.
// Optional AUTOSYM_STATS_EN adds stat_cnt_o, a count of vectors delivered downstream.
module autosym_proj_stage
  import autosym_pkg::*;
#(
  parameter int  N_IN  = AUTOSYM_N_IN,
  parameter int  N_OUT = AUTOSYM_N_OUT,
  localparam int ROW_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we_i,
  input  logic [ROW_W-1:0]  cfg_row_i,
  input  logic [N_IN-1:0]   cfg_data_i,
  input  logic              cfg_clear_i,
  output logic              cfg_ready_o,
  output logic              cfg_err_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N_IN-1:0]   in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N_OUT-1:0]  out_data_o,
  output logic              busy_o
`ifdef AUTOSYM_STATS_EN
  ,
  output logic [31:0]       stat_cnt_o
`endif
);

  localparam logic [ROW_W:0] N_OUT_W = (ROW_W+1)'(N_OUT);

  autosym_state_e             state_q, state_d;
  logic [N_OUT-1:0][N_IN-1:0] matrix_q, matrix_d;
  logic [N_OUT-1:0]           mask_q, mask_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       a_valid_q, a_valid_d;
  logic [N_IN-1:0]            a_data_q, a_data_d;
  logic                       b_valid_q, b_valid_d;
  logic [N_OUT-1:0]           b_data_q, b_data_d;

  logic [N_OUT-1:0]           z_s;
  logic                       cfg_ready_s;
  logic                       in_gate_s;
  logic                       unconf_entry_s;
  logic                       row_ok_s;
  logic                       wr_fire_s;
  logic                       a_adv_s;
  logic                       in_ready_s;
  logic                       in_fire_s;
  logic                       busy_s;
  logic                       out_fire_s;
  logic                       mask_full_s;

  assign busy_s      = a_valid_q | b_valid_q;
  assign mask_full_s = (mask_q == {N_OUT{1'b1}});
  assign out_fire_s  = b_valid_q & out_ready_i;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNCONF;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d        = state_q;
    unconf_entry_s = 1'b0;
    case (state_q)
      UNCONF: begin
        if (!cfg_clear_i && mask_full_s) begin
          state_d = RUN;
        end else begin
          state_d = UNCONF;
        end
      end
      RUN: begin
        if (cfg_clear_i) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!busy_s) begin
          state_d        = UNCONF;
          unconf_entry_s = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = UNCONF;
      end
    endcase
  end

  // FSM output decode
  always_comb begin
    cfg_ready_s = 1'b0;
    in_gate_s   = 1'b0;
    case (state_q)
      UNCONF:  cfg_ready_s = 1'b1;
      RUN:     in_gate_s   = 1'b1;
      DRAIN:   in_gate_s   = 1'b0;
      default: begin
        cfg_ready_s = 1'b0;
        in_gate_s   = 1'b0;
      end
    endcase
  end

  // Matrix and written-row mask update; a same-cycle clear overrides any write
  always_comb begin
    row_ok_s  = ({1'b0, cfg_row_i} < N_OUT_W);
    wr_fire_s = cfg_we_i & ~cfg_clear_i & cfg_ready_s & row_ok_s;
    cfg_err_d = cfg_we_i & ~cfg_clear_i & ~(cfg_ready_s & row_ok_s);
    matrix_d  = matrix_q;
    mask_d    = mask_q;
    if ((cfg_clear_i && (state_q == UNCONF)) || unconf_entry_s) begin
      mask_d = '0;
    end else if (wr_fire_s) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (cfg_row_i == ROW_W'(i)) begin
          matrix_d[i] = cfg_data_i;
          mask_d[i]   = 1'b1;
        end else begin
          matrix_d[i] = matrix_q[i];
        end
      end
    end else begin
      mask_d = mask_q;
    end
  end

  autosym_xor_reduce #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_xor_reduce (
    .matrix_i (matrix_q),
    .x_i      (a_data_q),
    .z_o      (z_s)
  );

  // Two-stage pipeline with a combinational ready chain back from the output
  always_comb begin
    a_adv_s    = ~b_valid_q | out_ready_i;
    in_ready_s = in_gate_s & (~a_valid_q | a_adv_s);
    in_fire_s  = in_valid_i & in_ready_s;
    a_valid_d  = a_valid_q;
    a_data_d   = a_data_q;
    b_valid_d  = b_valid_q;
    b_data_d   = b_data_q;
    if (in_fire_s) begin
      a_valid_d = 1'b1;
      a_data_d  = in_data_i;
    end else if (a_adv_s) begin
      a_valid_d = 1'b0;
    end else begin
      a_valid_d = a_valid_q;
    end
    if (a_adv_s) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_data_d = z_s;
      end else begin
        b_data_d = b_data_q;
      end
    end else begin
      b_valid_d = b_valid_q;
    end
  end

  // Datapath and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matrix_q  <= '0;
      mask_q    <= '0;
      cfg_err_q <= 1'b0;
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
    end else begin
      matrix_q  <= matrix_d;
      mask_q    <= mask_d;
      cfg_err_q <= cfg_err_d;
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
    end
  end

  assign cfg_ready_o = cfg_ready_s;
  assign cfg_err_o   = cfg_err_q;
  assign in_ready_o  = in_ready_s;
  assign out_valid_o = b_valid_q;
  assign out_data_o  = b_data_q;
  assign busy_o      = busy_s;

`ifdef AUTOSYM_STATS_EN
  logic [31:0] stat_q, stat_d;

  // Delivered-vector counter, restarted whenever the stage becomes unconfigured
  always_comb begin
    if (unconf_entry_s) begin
      stat_d = 32'd0;
    end else if (out_fire_s) begin
      stat_d = stat_q + 32'd1;
    end else begin
      stat_d = stat_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= 32'd0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt_o = stat_q;
`else
  logic unused_fire_s;
  assign unused_fire_s = out_fire_s;
`endif

endmodule

// File: tb/tb_autosym_proj_stage.sv
// Scoreboard bench for autosym_proj_stage: random streams against a
// popcount-parity reference model, plus directed configuration corner cases.
module tb_autosym_proj_stage;

  localparam int N_IN   = 24;
  localparam int N_OUT  = 16;
  localparam int N_OUT2 = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cfg_we, cfg_clear, cfg_ready, cfg_err;
  logic [3:0]  cfg_row;
  logic [23:0] cfg_data, in_data;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] out_data;

  logic        cfg_we2, cfg_clear2, cfg_ready2, cfg_err2;
  logic [3:0]  cfg_row2;
  logic [23:0] cfg_data2, in_data2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [11:0] out_data2;

`ifdef AUTOSYM_STATS_EN
  logic [31:0] stat_cnt, stat_cnt2;
  int          exp_stat = 0;
`endif

  autosym_proj_stage #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_we_i(cfg_we), .cfg_row_i(cfg_row), .cfg_data_i(cfg_data),
    .cfg_clear_i(cfg_clear), .cfg_ready_o(cfg_ready), .cfg_err_o(cfg_err),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy)
`ifdef AUTOSYM_STATS_EN
    , .stat_cnt_o(stat_cnt)
`endif
  );

  // Second instance with a non power-of-two row count exercises out-of-range rows
  autosym_proj_stage #(.N_IN(N_IN), .N_OUT(N_OUT2)) dut2 (
    .clk(clk), .rst(rst),
    .cfg_we_i(cfg_we2), .cfg_row_i(cfg_row2), .cfg_data_i(cfg_data2),
    .cfg_clear_i(cfg_clear2), .cfg_ready_o(cfg_ready2), .cfg_err_o(cfg_err2),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_data_i(in_data2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2), .out_data_o(out_data2),
    .busy_o(busy2)
`ifdef AUTOSYM_STATS_EN
    , .stat_cnt_o(stat_cnt2)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  logic [23:0] model_m [N_OUT];
  logic [15:0] sb_q [$];
  logic        mon_en = 1'b0;
  logic        rdy_mode = 1'b0;
  logic        rdy_val = 1'b1;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each output bit is the parity of the number of selected input ones
  function automatic logic [15:0] ref_z(input logic [23:0] x);
    logic [15:0] z;
    z = 16'd0;
    for (int i = 0; i < N_OUT; i++) z[i] = (($countones(model_m[i] & x) % 2) == 1);
    return z;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int row, input logic [23:0] data, input logic exp_ok);
    cfg_we = 1'b1; cfg_row = 4'(row); cfg_data = data;
    step();
    cfg_we = 1'b0;
    chk("cfg_err_pulse", {31'd0, cfg_err}, {31'd0, ~exp_ok});
    if (exp_ok) model_m[row] = data;
    step();
    chk("cfg_err_one_cycle", {31'd0, cfg_err}, 32'd0);
  endtask

  task automatic wr2(input int row, input logic [23:0] data, input logic exp_ok);
    cfg_we2 = 1'b1; cfg_row2 = 4'(row); cfg_data2 = data;
    step();
    cfg_we2 = 1'b0;
    chk("cfg_err2_pulse", {31'd0, cfg_err2}, {31'd0, ~exp_ok});
    step();
    chk("cfg_err2_one_cycle", {31'd0, cfg_err2}, 32'd0);
  endtask

  task automatic send(input logic [23:0] x);
    int  n;
    logic done;
    n = 0; done = 1'b0;
    in_valid = 1'b1; in_data = x;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(ref_z(x));
        step();
        done = 1'b1;
      end else if (n > 200) begin
        chk("send_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end else begin
        n++;
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 2000) begin
      step();
      n++;
    end
    chk("idle_sb_empty", sb_q.size(), 32'd0);
  endtask

  task automatic do_clear();
    int n;
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    n = 0;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
    end
    chk("clear_to_unconf", {31'd0, cfg_ready}, 32'd1);
`ifdef AUTOSYM_STATS_EN
    exp_stat = 0;
`endif
  endtask

  // out_ready driver: fixed value or a fresh coin flip each cycle
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_stall) begin
          chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
          chk("stall_data_hold", {16'd0, out_data}, {16'd0, prev_data});
        end
        if (out_valid && out_ready) begin
`ifdef AUTOSYM_STATS_EN
          exp_stat++;
`endif
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %0h expected no output", out_data);
          end else if (out_data !== sb_q[0]) begin
            errors++;
            $display("FAIL out_data: got %0h expected %0h", out_data, sb_q[0]);
            void'(sb_q.pop_front());
          end else begin
            void'(sb_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] va, vb;
    int n;
    cfg_we = 1'b0; cfg_row = 4'd0; cfg_data = 24'd0; cfg_clear = 1'b0;
    in_valid = 1'b0; in_data = 24'd0;
    cfg_we2 = 1'b0; cfg_row2 = 4'd0; cfg_data2 = 24'd0; cfg_clear2 = 1'b0;
    in_valid2 = 1'b0; in_data2 = 24'd0; out_ready2 = 1'b1;
    for (int i = 0; i < N_OUT; i++) model_m[i] = 24'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Identity-like one-hot rows, directed latency check
    for (int i = 0; i < N_OUT; i++) wr(i, 24'd1 << i, 1'b1);
    chk("run_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    chk("run_in_ready", {31'd0, in_ready}, 32'd1);
    send(24'h00A5C3);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {16'd0, out_data}, 32'h0000A5C3);
    wait_idle();

    // Row 0 all ones, others zero
    do_clear();
    wr(0, 24'hFFFFFF, 1'b1);
    for (int i = 1; i < N_OUT; i++) wr(i, 24'd0, 1'b1);
    send(24'h000007);
    send(24'h000003);
    wait_idle();

    // Random matrix, random stream under random backpressure
    do_clear();
    for (int i = 0; i < N_OUT; i++) wr(i, 24'($urandom), 1'b1);
    rdy_mode = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(24'($urandom));
    end
    rdy_mode = 1'b0;
    wait_idle();
`ifdef AUTOSYM_STATS_EN
    chk("stat_cnt", stat_cnt, 32'(exp_stat));
`endif

    // Write while running must be rejected and leave row 3 unchanged
    wr(3, ~model_m[3], 1'b0);
    chk("run_after_reject", {31'd0, cfg_ready}, 32'd0);
    send(24'h000001);
    send(24'h000003);
    wait_idle();

    // Out-of-range row and clear-vs-write priority on the 12-row instance
    for (int i = 0; i < 11; i++) wr2(i, 24'($urandom), 1'b1);
    wr2(13, 24'($urandom), 1'b0);
    chk("oor_stays_unconf", {31'd0, cfg_ready2}, 32'd1);
    cfg_clear2 = 1'b1; cfg_we2 = 1'b1; cfg_row2 = 4'd11; cfg_data2 = 24'h123456;
    step();
    cfg_clear2 = 1'b0; cfg_we2 = 1'b0;
    chk("clear_we_no_err", {31'd0, cfg_err2}, 32'd0);
    wr2(11, 24'h00FF00, 1'b1);
    chk("mask_was_cleared", {31'd0, cfg_ready2}, 32'd1);
    for (int i = 0; i < 11; i++) wr2(i, 24'($urandom), 1'b1);
    chk("dut2_run", {31'd0, cfg_ready2}, 32'd0);
    wr2(2, 24'h000001, 1'b0);

    // Clear with two vectors in flight: both drain, no input accepted
    va = 24'($urandom); vb = 24'($urandom);
    send(va);
    send(vb);
    chk("inflight_busy", {31'd0, busy}, 32'd1);
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    in_valid = 1'b1; in_data = 24'($urandom);
    n = 0;
    while (!cfg_ready && n < 20) begin
      chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("drain_unconf", {31'd0, cfg_ready}, 32'd1);
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("drain_all_out", sb_q.size(), 32'd0);

    // Reset during a fully stalled pipeline
    for (int i = 0; i < N_OUT; i++) wr(i, 24'($urandom), 1'b1);
    rdy_val = 1'b0;
    step();
    step();
    send(24'($urandom));
    send(24'($urandom));
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    mon_en = 1'b0;
    sb_q.delete();
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_unconf", {31'd0, cfg_ready}, 32'd1);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef AUTOSYM_STATS_EN
    chk("mrst_stat", stat_cnt, 32'd0);
`endif
    rdy_val = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
